tx_nco_freq_sched: RTL and testbench

Frequency scheduler for the TX NCO. It accepts phase-increment change requests from two requesters: requester 0 is the CPU configuration path, requester 1 is the tune/keyer path. It arbitrates between them and applies each change to the NCO's `phi_inc_i`, either as an instant step or as a linear glide. It drives the NCO `clken` from a sample tick and produces a mute flag covering the NCO pipeline settling after any hard jump.

---
 rtl/tx_nco_pkg.sv | 18 +
 rtl/tx_nco_rr_arb2.sv | 25 ++
 rtl/tx_nco_freq_sched.sv | 123 ++++++++++++
 tb/tb_tx_nco_freq_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_nco_pkg.sv
// Shared types and defaults for the TX NCO frequency scheduler.
package tx_nco_pkg;

  localparam int unsigned APR_DEF       = 22;
  localparam int unsigned RAMP_LOG2_DEF = 4;
  localparam int unsigned SETTLE_DEF    = 8;

  localparam int unsigned REQ_CPU  = 0;
  localparam int unsigned REQ_TUNE = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_RAMP,
    ST_SETTLE
  } state_t;

endpackage

// File: rtl/tx_nco_rr_arb2.sv
// Two-input round-robin arbiter; the pointer favours the requester that lost last.
module tx_nco_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic prio;

  always_comb begin
    grant = '0;
    if (en) begin
      if (valid[prio])       grant[prio]  = 1'b1;
      else if (valid[~prio]) grant[~prio] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           prio <= 1'b0;
    else if (|grant)     prio <= grant[0];
  end

endmodule

// File: rtl/tx_nco_freq_sched.sv
// Arbitrates phase-increment change requests and applies them to the NCO as a
// step (with settle mute) or a linear glide, updating only on sample ticks.
module tx_nco_freq_sched
  import tx_nco_pkg::*;
#(
  parameter int unsigned APR       = APR_DEF,
  parameter int unsigned RAMP_LOG2 = RAMP_LOG2_DEF,
  parameter int unsigned SETTLE    = SETTLE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick_i,
  input  logic [1:0]     req_valid_i,
  output logic [1:0]     req_ready_o,
  input  logic [APR-1:0] req_inc0_i,
  input  logic [APR-1:0] req_inc1_i,
  input  logic [1:0]     req_glide_i,
  output logic           nco_clken_o,
  output logic [APR-1:0] phi_inc_o,
  input  logic           nco_valid_i,
  output logic           mute_o,
  output logic           busy_o
);

  localparam logic [15:0] RAMP_LAST   = 16'((1 << RAMP_LOG2) - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  state_t              state_q, state_d;
  logic [1:0]          grant;
  logic                gsel, sel_glide;
  logic [APR-1:0]      sel_inc, target_q, phi_q;
  logic signed [APR:0] delta, stepv_q, ramp_sum;
  logic [15:0]         cnt_q, st_cnt_q;
  logic                clken_q, step_mute_q, startup_done_q, seen_q;
  logic                ramp_done, settle_done;

  tx_nco_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_IDLE && !reset),
    .valid (req_valid_i),
    .grant (grant)
  );

  assign gsel      = grant[REQ_TUNE];
  assign sel_inc   = gsel ? req_inc1_i : req_inc0_i;
  assign sel_glide = gsel ? req_glide_i[REQ_TUNE] : req_glide_i[REQ_CPU];

  // Increment is unsigned and never wraps; extend by one bit so the difference is signed.
  assign delta    = $signed({1'b0, sel_inc}) - $signed({1'b0, phi_q});
  assign ramp_sum = $signed({1'b0, phi_q}) + stepv_q;

  assign ramp_done   = tick_i && (cnt_q == RAMP_LAST);
  assign settle_done = tick_i && (cnt_q == SETTLE_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|grant) state_d = sel_glide ? ST_RAMP : ST_STEP;
      ST_STEP:   if (tick_i) state_d = ST_SETTLE;
      ST_RAMP:   if (ramp_done) state_d = ST_IDLE;
      ST_SETTLE: if (settle_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clken_q        <= 1'b0;
      phi_q          <= '0;
      target_q       <= '0;
      stepv_q        <= '0;
      cnt_q          <= '0;
      step_mute_q    <= 1'b0;
      startup_done_q <= 1'b0;
      seen_q         <= 1'b0;
      st_cnt_q       <= '0;
    end else begin
      clken_q <= tick_i;
      if (|grant) begin
        target_q <= sel_inc;
        stepv_q  <= delta >>> RAMP_LOG2;
        cnt_q    <= '0;
      end
      unique case (state_q)
        ST_STEP: if (tick_i) begin
          phi_q       <= target_q;
          step_mute_q <= 1'b1;
          cnt_q       <= '0;
        end
        // Last glide tick loads the target exactly, absorbing truncation error.
        ST_RAMP: if (tick_i) begin
          cnt_q <= cnt_q + 16'd1;
          phi_q <= ramp_done ? target_q : ramp_sum[APR-1:0];
        end
        ST_SETTLE: if (tick_i) begin
          cnt_q <= cnt_q + 16'd1;
          if (settle_done) step_mute_q <= 1'b0;
        end
        default: ;
      endcase
      if (!startup_done_q) begin
        if (nco_valid_i) seen_q <= 1'b1;
        if (tick_i && (seen_q || nco_valid_i)) begin
          if (st_cnt_q == SETTLE_LAST) startup_done_q <= 1'b1;
          else                         st_cnt_q       <= st_cnt_q + 16'd1;
        end
      end
    end
  end

  assign req_ready_o = grant;
  assign nco_clken_o = clken_q;
  assign phi_inc_o   = phi_q;
  assign mute_o      = step_mute_q | ~startup_done_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_nco_freq_sched.sv
// Randomized self-checking bench for tx_nco_freq_sched against an arithmetic reference model.
module tb_tx_nco_freq_sched;

  localparam int APR = 22;
  localparam int RL  = 4;
  localparam int ST  = 8;
  localparam int NR  = 1 << RL;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           tick_i = 1'b0;
  logic [1:0]     req_valid_i = '0;
  logic [1:0]     req_ready_o;
  logic [APR-1:0] req_inc0_i = '0;
  logic [APR-1:0] req_inc1_i = '0;
  logic [1:0]     req_glide_i = '0;
  logic           nco_clken_o;
  logic [APR-1:0] phi_inc_o;
  logic           nco_valid_i = 1'b0;
  logic           mute_o;
  logic           busy_o;

  int n_chk = 0;
  int n_pass = 0;
  int m_phi = 0;
  int m_prio = 0;

  tx_nco_freq_sched #(.APR(APR), .RAMP_LOG2(RL), .SETTLE(ST)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_i      (tick_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_inc0_i  (req_inc0_i),
    .req_inc1_i  (req_inc1_i),
    .req_glide_i (req_glide_i),
    .nco_clken_o (nco_clken_o),
    .phi_inc_o   (phi_inc_o),
    .nco_valid_i (nco_valid_i),
    .mute_o      (mute_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic cyc(input bit t);
    tick_i = t;
    @(posedge clk);
    #1;
    tick_i = 1'b0;
  endtask

  function automatic int floor_div(input int d);
    if (d >= 0) return d / NR;
    return -((-d + NR - 1) / NR);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req_valid_i = '0;
    nco_valid_i = 1'b0;
    repeat (3) cyc(1);
    n_chk++; if (phi_inc_o !== '0) $display("FAIL reset_phi got %h want 0", phi_inc_o); else n_pass++;
    n_chk++; if (nco_clken_o !== 1'b0) $display("FAIL reset_clken got %b want 0", nco_clken_o); else n_pass++;
    n_chk++; if (req_ready_o !== 2'b00) $display("FAIL reset_ready got %b want 00", req_ready_o); else n_pass++;
    n_chk++; if (mute_o !== 1'b1) $display("FAIL reset_mute got %b want 1", mute_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
    reset = 1'b0;
    m_phi = 0;
    m_prio = 0;
    for (int t = 1; t <= 5; t++) begin
      repeat (3) cyc(0);
      cyc(1);
      n_chk++; if (mute_o !== 1'b1) $display("FAIL startup_premute tick %0d got %b want 1", t, mute_o); else n_pass++;
      n_chk++; if (nco_clken_o !== 1'b1) $display("FAIL clken_tick got %b want 1", nco_clken_o); else n_pass++;
    end
    nco_valid_i = 1'b1;
    for (int k = 1; k <= ST; k++) begin
      cyc(0);
      if (k == 1) begin
        n_chk++; if (nco_clken_o !== 1'b0) $display("FAIL clken_idle got %b want 0", nco_clken_o); else n_pass++;
      end
      repeat (2) cyc(0);
      cyc(1);
      n_chk++; if (mute_o !== (k < ST)) $display("FAIL startup_mute tick %0d got %b want %b", k, mute_o, k < ST); else n_pass++;
      n_chk++; if (phi_inc_o !== '0) $display("FAIL startup_phi got %h want 0", phi_inc_o); else n_pass++;
    end
  endtask

  task automatic drive_req(input int r, input int tgt, input bit glide);
    req_valid_i = 2'b00;
    req_valid_i[r] = 1'b1;
    req_glide_i[r] = glide;
    if (r == 0) req_inc0_i = APR'(tgt);
    else        req_inc1_i = APR'(tgt);
  endtask

  task automatic test_step(input int r, input int tgt, input bit grant_tick);
    logic [1:0] exp_rdy;
    exp_rdy = 2'b00;
    exp_rdy[r] = 1'b1;
    drive_req(r, tgt, 1'b0);
    #2;
    n_chk++; if (req_ready_o !== exp_rdy) $display("FAIL step_ready got %b want %b", req_ready_o, exp_rdy); else n_pass++;
    cyc(grant_tick);
    req_valid_i = 2'b00;
    m_prio = (r == 0) ? 1 : 0;
    n_chk++; if (busy_o !== 1'b1 || phi_inc_o !== APR'(m_phi)) $display("FAIL step_grant busy %b phi %h want 1 %h", busy_o, phi_inc_o, APR'(m_phi)); else n_pass++;
    n_chk++; if (req_ready_o !== 2'b00) $display("FAIL step_ready_pulse got %b want 00", req_ready_o); else n_pass++;
    cyc(0);
    cyc(1);
    m_phi = tgt;
    n_chk++; if (phi_inc_o !== APR'(tgt)) $display("FAIL step_phi got %h want %h", phi_inc_o, APR'(tgt)); else n_pass++;
    n_chk++; if (mute_o !== 1'b1) $display("FAIL step_mute_rise got %b want 1", mute_o); else n_pass++;
    for (int k = 1; k <= ST; k++) begin
      cyc(0);
      cyc(1);
      n_chk++; if (mute_o !== (k < ST) || busy_o !== (k < ST))
        $display("FAIL step_settle tick %0d mute %b busy %b want %b", k, mute_o, busy_o, k < ST); else n_pass++;
    end
  endtask

  task automatic test_glide(input int r, input int tgt, input bit grant_tick, input bit chk_mute);
    logic [1:0] exp_rdy;
    int cur, sv, ex, lo, hi;
    exp_rdy = 2'b00;
    exp_rdy[r] = 1'b1;
    drive_req(r, tgt, 1'b1);
    #2;
    n_chk++; if (req_ready_o !== exp_rdy) $display("FAIL glide_ready got %b want %b", req_ready_o, exp_rdy); else n_pass++;
    cyc(grant_tick);
    req_valid_i = 2'b00;
    m_prio = (r == 0) ? 1 : 0;
    n_chk++; if (busy_o !== 1'b1 || phi_inc_o !== APR'(m_phi)) $display("FAIL glide_grant busy %b phi %h want 1 %h", busy_o, phi_inc_o, APR'(m_phi)); else n_pass++;
    cur = m_phi;
    sv = floor_div(tgt - cur);
    lo = (cur < tgt) ? cur : tgt;
    hi = (cur < tgt) ? tgt : cur;
    for (int k = 1; k <= NR; k++) begin
      repeat ($urandom_range(0, 2)) cyc(0);
      cyc(1);
      ex = (k < NR) ? cur + k * sv : tgt;
      n_chk++; if (phi_inc_o !== APR'(ex)) $display("FAIL glide_phi tick %0d got %h want %h", k, phi_inc_o, APR'(ex)); else n_pass++;
      n_chk++; if (int'(phi_inc_o) < lo || int'(phi_inc_o) > hi) $display("FAIL glide_bounds tick %0d got %h want in [%h,%h]", k, phi_inc_o, lo, hi); else n_pass++;
      n_chk++; if (busy_o !== (k < NR)) $display("FAIL glide_busy tick %0d got %b want %b", k, busy_o, k < NR); else n_pass++;
      if (chk_mute) begin
        n_chk++; if (mute_o !== 1'b0) $display("FAIL glide_mute tick %0d got %b want 0", k, mute_o); else n_pass++;
      end
    end
    m_phi = tgt;
  endtask

  task automatic test_contention();
    int g;
    logic [1:0] exp_rdy;
    logic [APR-1:0] inc [2];
    reset = 1'b1;
    repeat (2) cyc(0);
    reset = 1'b0;
    m_phi = 0;
    m_prio = 0;
    inc[0] = APR'($urandom);
    inc[1] = APR'($urandom);
    req_inc0_i = inc[0];
    req_inc1_i = inc[1];
    req_glide_i = 2'b00;
    req_valid_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      g = m_prio;
      exp_rdy = 2'b00;
      exp_rdy[g] = 1'b1;
      #2;
      n_chk++; if (req_ready_o !== exp_rdy) $display("FAIL contend_grant %0d got %b want %b", i, req_ready_o, exp_rdy); else n_pass++;
      cyc(0);
      m_prio = (g == 0) ? 1 : 0;
      for (int c = 0; c <= ST; c++) begin
        #2;
        n_chk++; if (req_ready_o !== 2'b00 || busy_o !== 1'b1)
          $display("FAIL contend_busy %0d.%0d ready %b busy %b want 00 1", i, c, req_ready_o, busy_o); else n_pass++;
        cyc(1);
      end
      n_chk++; if (phi_inc_o !== inc[g]) $display("FAIL contend_phi %0d got %h want %h", i, phi_inc_o, inc[g]); else n_pass++;
      m_phi = int'(inc[g]);
    end
    req_valid_i = 2'b00;
    #2;
  endtask

  task automatic test_reset_mid_glide();
    int r, tgt, sv, cur;
    r = int'($urandom_range(0, 1));
    tgt = int'($urandom_range(0, (1 << APR) - 1));
    drive_req(r, tgt, 1'b1);
    cyc(0);
    req_valid_i = 2'b00;
    cur = m_phi;
    sv = floor_div(tgt - cur);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      n_chk++; if (phi_inc_o !== APR'(cur + k * sv)) $display("FAIL abort_phi tick %0d got %h want %h", k, phi_inc_o, APR'(cur + k * sv)); else n_pass++;
    end
    reset = 1'b1;
    req_valid_i[r] = 1'b1;
    #2;
    n_chk++; if (req_ready_o !== 2'b00) $display("FAIL abort_ready_busy got %b want 00", req_ready_o); else n_pass++;
    cyc(1);
    n_chk++; if (phi_inc_o !== '0 || nco_clken_o !== 1'b0 || mute_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL abort_reset phi %h clken %b mute %b busy %b want 0 0 1 0", phi_inc_o, nco_clken_o, mute_o, busy_o); else n_pass++;
    n_chk++; if (req_ready_o !== 2'b00) $display("FAIL abort_ready_reset got %b want 00", req_ready_o); else n_pass++;
    cyc(0);
    reset = 1'b0;
    m_phi = 0;
    m_prio = 0;
    test_glide(r, int'($urandom_range(0, (1 << APR) - 1)), 1'b0, 1'b0);
  endtask

  initial begin
    int r, t;
    test_reset();
    test_glide(0, 'h000100, 1'b0, 1'b1);
    test_step(1, 'h000105, 1'b1);
    test_glide(0, 'h000000, 1'b1, 1'b1);
    test_step(0, 'h0A0000, 1'b0);
    test_step(1, 'h0A0000, 1'b0);
    test_glide(0, 'h0A0000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(0, 1));
      t = int'($urandom_range(0, (1 << APR) - 1));
      if ($urandom_range(0, 1) == 1) test_glide(r, t, 1'($urandom_range(0, 1)), 1'b1);
      else                           test_step(r, t, 1'($urandom_range(0, 1)));
    end
    test_contention();
    test_reset_mid_glide();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
